// File: rtl/bresenham_line_pkg.sv
// Shared types for the line-drawing stage: pixel coordinate, FSM state and screen bounds.
// Screen bounds come from `WIDTH/`HEIGHT; the defaults below apply when the build does not set them.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

package bresenham_line_pkg;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
   } Point2D;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } BresenState;

   localparam logic signed [15:0] SCREEN_W = 16'(`WIDTH);
   localparam logic signed [15:0] SCREEN_H = 16'(`HEIGHT);

   function automatic logic on_screen(input Point2D pt);
      return (pt.x >= 16'sd0) && (pt.x < SCREEN_W) &&
             (pt.y >= 16'sd0) && (pt.y < SCREEN_H);
   endfunction

endpackage

// File: rtl/bresenham_line_step.sv
// One Bresenham step: next (cur, err) from the current point, error and line constants.
// Purely combinational so a later span/fill stage can reuse it unchanged.
module bresenham_step
   import bresenham_line_pkg::*;
#(
   parameter int ERR_W = 19
)
(
   input  Point2D                   cur_i,
   input  logic signed [ERR_W-1:0]  err_i,
   input  logic signed [16:0]       dx_i,
   input  logic signed [16:0]       dy_i,
   input  logic                     sx_neg_i,
   input  logic                     sy_neg_i,
   output Point2D                   cur_o,
   output logic signed [ERR_W-1:0]  err_o
);

   localparam logic signed [15:0] STEP_POS = 16'sd1;
   localparam logic signed [15:0] STEP_NEG = -16'sd1;

   logic signed [ERR_W-1:0] e2;
   logic signed [ERR_W-1:0] dx_ext;
   logic signed [ERR_W-1:0] dy_ext;

   assign e2     = err_i <<< 1;
   assign dx_ext = ERR_W'(dx_i);
   assign dy_ext = ERR_W'(dy_i);

   // Both axis decisions use the same pre-step error, so a diagonal move adds dy and dx together.
   always_comb begin
      cur_o = cur_i;
      err_o = err_i;
      if (e2 >= dy_ext) begin
         err_o   = err_o + dy_ext;
         cur_o.x = cur_i.x + (sx_neg_i ? STEP_NEG : STEP_POS);
      end
      if (e2 <= dx_ext) begin
         err_o   = err_o + dx_ext;
         cur_o.y = cur_i.y + (sy_neg_i ? STEP_NEG : STEP_POS);
      end
   end

endmodule

// File: rtl/bresenham_line.sv
// Edge walker: latches p/q on start, emits one pixel per accepted cycle, then pulses done.
// Optional RASTER_CLIP_EN suppresses pixel_valid for off-screen points without slowing the walk.
//
//   state | meaning
//   IDLE  | waiting for start; endpoints latched on start
//   SETUP | compute dx, dy, step directions and initial error
//   DRAW  | present cur as pixel; advance on accept (no stall)
//   DONE  | one-cycle done pulse, back to IDLE
module bresenham_line
   import bresenham_line_pkg::*;
#(
   parameter int ERR_W = 19
)
(
   input  logic    clk,
   input  logic    n_rst,
   input  logic    start,
   input  Point2D  p,
   input  Point2D  q,
   input  logic    stall,
   output Point2D  pixel,
   output logic    pixel_valid,
   output logic    busy,
   output logic    done
);

   BresenState               state_q;
   Point2D                   cur_q;
   Point2D                   end_q;
   logic signed [16:0]       dx_q;
   logic signed [16:0]       dy_q;
   logic                     sx_neg_q;
   logic                     sy_neg_q;
   logic signed [ERR_W-1:0]  err_q;
   logic                     pv_q;
   logic                     busy_q;
   logic                     done_q;

   logic signed [16:0]       diff_x;
   logic signed [16:0]       diff_y;
   logic signed [16:0]       abs_x;
   logic signed [16:0]       abs_y;
   Point2D                   step_cur;
   logic signed [ERR_W-1:0]  step_err;
   logic                     vis_cur;
   logic                     vis_nxt;
   logic                     accept;
   logic                     at_end;

   always_comb begin
      diff_x = 17'(end_q.x) - 17'(cur_q.x);
      diff_y = 17'(end_q.y) - 17'(cur_q.y);
      abs_x  = diff_x[16] ? -diff_x : diff_x;
      abs_y  = diff_y[16] ? -diff_y : diff_y;
   end

   bresenham_step #(
      .ERR_W    (ERR_W)
   ) u_step (
      .cur_i    (cur_q),
      .err_i    (err_q),
      .dx_i     (dx_q),
      .dy_i     (dy_q),
      .sx_neg_i (sx_neg_q),
      .sy_neg_i (sy_neg_q),
      .cur_o    (step_cur),
      .err_o    (step_err)
   );

`ifdef RASTER_CLIP_EN
   assign vis_cur = on_screen(cur_q);
   assign vis_nxt = on_screen(step_cur);
`else
   assign vis_cur = 1'b1;
   assign vis_nxt = 1'b1;
`endif

   // Off-screen points are never written, so backpressure cannot hold them.
   assign accept = (state_q == DRAW) && (!stall || !vis_cur);
   assign at_end = (cur_q == end_q);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         end_q    <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
         err_q    <= '0;
         pv_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               pv_q <= 1'b0;
               if (start) begin
                  cur_q   <= p;
                  end_q   <= q;
                  busy_q  <= 1'b1;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               dx_q     <= abs_x;
               dy_q     <= -abs_y;
               sx_neg_q <= !(cur_q.x < end_q.x);
               sy_neg_q <= !(cur_q.y < end_q.y);
               err_q    <= ERR_W'(abs_x) - ERR_W'(abs_y);
               pv_q     <= vis_cur;
               state_q  <= DRAW;
            end
            DRAW: begin
               if (accept) begin
                  if (at_end) begin
                     pv_q    <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cur_q <= step_cur;
                     err_q <= step_err;
                     pv_q  <= vis_nxt;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pixel       = cur_q;
   assign pixel_valid = pv_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
